// File: rtl/dlx_imem_responder_pkg.sv
// Shared definitions for the DLX instruction-memory responder: word size, NOP encoding
// and the responder state codes.
package dlx_imem_responder_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [5:0] SPECIAL   = 6'b000000;
    localparam logic [5:0] NOP_FUNCT = 6'b010101;

    localparam logic [WORD_SIZE-1:0] NOP_WORD = {SPECIAL, 20'b0, NOP_FUNCT};

    typedef enum logic {
        IM_CLEAR = 1'b0,
        IM_READY = 1'b1
    } im_state_t;

endpackage

// File: rtl/dlx_imem_array.sv
// DEPTH x DATA_W instruction store: one synchronous write port and one registered read port.
module dlx_imem_array #(
    parameter int DEPTH  = 26,
    parameter int AW     = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata_p1
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a same-edge read of the written index sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_p1 <= mem[raddr];
        end
    end

endmodule

// File: rtl/dlx_imem_responder.sv
// Memory end of the DLX fetch interface: clears its store to NOP after reset, then serves
// single-cycle-latency fetches and accepts program words through a load port.
module dlx_imem_responder
    import dlx_imem_responder_pkg::*;
#(
    parameter int DEPTH = 26,
    parameter int AW    = 5
) (
    input  logic                 PHI1,
    input  logic                 MRST,
    input  logic [31:0]          IAddr,
    input  logic                 IRead,
    output logic [31:0]          IIn,
    output logic                 IValid,
    output logic                 IErr,
    input  logic                 LdEn,
    input  logic [AW-1:0]        LdAddr,
    input  logic [31:0]          LdData,
    output logic                 Busy
);

    localparam logic [31:0]   ADDR_LIMIT = 32'(4 * DEPTH);
    localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);

    im_state_t                state;
    logic [AW-1:0]            cnt;
    logic                     use_mem_p1;
    logic [WORD_SIZE-1:0]     rdata_p1;

    logic                     fetch_ok_p0;
    logic                     fetch_bad_p0;
    logic                     ld_ok_p0;
    logic                     we_p0;
    logic [AW-1:0]            waddr_p0;
    logic [WORD_SIZE-1:0]     wdata_p0;

    function automatic logic addr_in_range(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < ADDR_LIMIT);
    endfunction

    assign fetch_ok_p0  = IRead && (state == IM_READY) && addr_in_range(IAddr);
    assign fetch_bad_p0 = IRead && (state == IM_READY) && !addr_in_range(IAddr);
    assign ld_ok_p0     = LdEn && (32'(LdAddr) < 32'(DEPTH));

    // The sweep owns the write port while clearing; the load port owns it once ready.
    always_comb begin
        we_p0    = 1'b0;
        waddr_p0 = LdAddr;
        wdata_p0 = LdData;
        if (!MRST) begin
            if (state == IM_CLEAR) begin
                we_p0    = 1'b1;
                waddr_p0 = cnt;
                wdata_p0 = NOP_WORD;
            end else if (ld_ok_p0) begin
                we_p0 = 1'b1;
            end
        end
    end

    dlx_imem_array #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W (WORD_SIZE)
    ) u_array (
        .clk      (PHI1),
        .we       (we_p0),
        .waddr    (waddr_p0),
        .wdata    (wdata_p0),
        .re       (fetch_ok_p0 && !MRST),
        .raddr    (IAddr[AW+1:2]),
        .rdata_p1 (rdata_p1)
    );

    // ---- p0 -> p1: fetch response flags and sweep control
    always_ff @(posedge PHI1) begin
        if (MRST) begin
            state      <= IM_CLEAR;
            cnt        <= '0;
            Busy       <= 1'b1;
            IValid     <= 1'b0;
            IErr       <= 1'b0;
            use_mem_p1 <= 1'b0;
        end else begin
            IValid <= IRead;
            IErr   <= fetch_bad_p0;
            if (IRead) begin
                use_mem_p1 <= fetch_ok_p0;
            end
            case (state)
                IM_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state <= IM_READY;
                        Busy  <= 1'b0;
                    end
                end
                IM_READY: begin
                    state <= IM_READY;
                end
                default: begin
                    state <= IM_CLEAR;
                end
            endcase
        end
    end

    // IIn holds while IRead is low because neither use_mem_p1 nor the read register moves.
    assign IIn = use_mem_p1 ? rdata_p1 : NOP_WORD;

endmodule

// File: tb/tb_dlx_imem_responder.sv
// Directed self-checking bench for dlx_imem_responder.
module tb_dlx_imem_responder;

    localparam int          DEPTH = 26;
    localparam int          AW    = 5;
    localparam logic [31:0] NOPW  = 32'h0000_0015;

    logic          clk = 1'b0;
    logic          MRST;
    logic [31:0]   IAddr;
    logic          IRead;
    logic [31:0]   IIn;
    logic          IValid;
    logic          IErr;
    logic          LdEn;
    logic [AW-1:0] LdAddr;
    logic [31:0]   LdData;
    logic          Busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_mem [DEPTH];

    always #5 clk = ~clk;

    dlx_imem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .PHI1   (clk),
        .MRST   (MRST),
        .IAddr  (IAddr),
        .IRead  (IRead),
        .IIn    (IIn),
        .IValid (IValid),
        .IErr   (IErr),
        .LdEn   (LdEn),
        .LdAddr (LdAddr),
        .LdData (LdData),
        .Busy   (Busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_word, input logic exp_err,
                         input string tag);
        IRead = 1'b1;
        IAddr = a;
        tick();
        chk({tag, " IIn"}, IIn, exp_word);
        chk({tag, " IValid"}, 32'(IValid), 32'd1);
        chk({tag, " IErr"}, 32'(IErr), 32'(exp_err));
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        LdEn   = 1'b1;
        LdAddr = a;
        LdData = d;
        tick();
        LdEn   = 1'b0;
        if (32'(a) < DEPTH) exp_mem[a] = d;
    endtask

    task automatic count_busy(input string tag, input logic fetch_during);
        int  n;
        logic prev;
        n = 0;
        IRead = fetch_during;
        IAddr = 32'd0;
        while (Busy === 1'b1 && n < 40) begin
            prev = Busy;
            tick();
            n++;
            if (fetch_during && prev) begin
                chk({tag, " clear IIn"}, IIn, NOPW);
                chk({tag, " clear IValid"}, 32'(IValid), 32'd1);
                chk({tag, " clear IErr"}, 32'(IErr), 32'd0);
            end
        end
        chk({tag, " busy cycles"}, 32'(n), 32'd26);
        IRead = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = NOPW;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        MRST = 1'b1; IAddr = '0; IRead = 1'b0; LdEn = 1'b0; LdAddr = '0; LdData = '0;
        tick();
        chk("reset Busy", 32'(Busy), 32'd1);
        chk("reset IValid", 32'(IValid), 32'd0);
        chk("reset IErr", 32'(IErr), 32'd0);
        chk("reset IIn", IIn, NOPW);
        MRST = 1'b0;

        // 1: clear sweep then fetch every word
        count_busy("t1", 1'b0);
        chk("t1 Busy low", 32'(Busy), 32'd0);
        for (int a = 0; a <= 100; a += 4) fetch(32'(a), NOPW, 1'b0, "t1 fetch");

        // 2: load two words and fetch back-to-back
        IRead = 1'b0;
        load(5'd0, 32'h2021_0001);
        load(5'd1, 32'h0021_1020);
        fetch(32'd0, 32'h2021_0001, 1'b0, "t2 w0");
        fetch(32'd4, 32'h0021_1020, 1'b0, "t2 w1");
        IRead = 1'b0;
        tick();
        chk("t2 idle IValid", 32'(IValid), 32'd0);
        chk("t2 idle IErr", 32'(IErr), 32'd0);
        chk("t2 idle IIn hold", IIn, 32'h0021_1020);

        // 3: out-of-range and misaligned
        fetch(32'd104, NOPW, 1'b1, "t3 104");
        fetch(32'hFFFF_FFFC, NOPW, 1'b1, "t3 top");
        fetch(32'd6, NOPW, 1'b1, "t3 mis");
        fetch(32'd100, NOPW, 1'b0, "t3 last");
        fetch(32'd0, 32'h2021_0001, 1'b0, "t3 recover");

        // 4: read-before-write, then simultaneous load/fetch on different indices
        LdEn = 1'b1; LdAddr = 5'd3; LdData = 32'hDEAD_BEEF;
        fetch(32'd12, NOPW, 1'b0, "t4 rbw");
        exp_mem[3] = 32'hDEAD_BEEF;
        LdEn = 1'b0;
        fetch(32'd12, 32'hDEAD_BEEF, 1'b0, "t4 new");
        LdEn = 1'b1; LdAddr = 5'd7; LdData = 32'h1234_5678;
        fetch(32'd4, 32'h0021_1020, 1'b0, "t4 par rd");
        exp_mem[7] = 32'h1234_5678;
        LdEn = 1'b0;
        fetch(32'd28, 32'h1234_5678, 1'b0, "t4 par wr");

        // 5: reset mid-sweep restarts the clear
        IRead = 1'b0;
        MRST = 1'b1;
        tick();
        MRST = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t5 mid Busy", 32'(Busy), 32'd1);
        MRST = 1'b1;
        tick();
        chk("t5 rst IValid", 32'(IValid), 32'd0);
        MRST = 1'b0;
        count_busy("t5", 1'b1);
        fetch(32'd0, NOPW, 1'b0, "t5 w0");
        fetch(32'd12, NOPW, 1'b0, "t5 w3");
        fetch(32'd28, NOPW, 1'b0, "t5 w7");

        // 6: dropped out-of-range load, then full scoreboard sweep
        IRead = 1'b0;
        load(5'd2, 32'hAAAA_5555);
        load(5'd25, 32'h0BAD_F00D);
        load(5'd30, 32'hFFFF_FFFF);
        load(5'd4, 32'h0000_0004);
        for (int a = 0; a <= 100; a += 4) fetch(32'(a), exp_mem[a/4], 1'b0, "t6 sweep");
        IRead = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
